// File: rtl/spike_out_aer.sv
// AER spike encoder: queues {eot, timestep, neuron address} events in a FIFO drained over valid/ready.
// Optional end-of-timestep markers are enabled by defining SPIKE_OUT_EOT_EN.
module spike_out_aer #(
  parameter int NEURON_NO  = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_W       = 16,
  parameter int OVF_W      = 8,
  localparam int AW = $clog2(NEURON_NO),
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sys_en,
  input  logic            dt_tick,
  input  logic            update_en,
  input  logic [AW-1:0]   sp_out_wr_addr,
  input  logic            sp_out,
  input  logic            aer_ready,
  output logic            aer_valid,
  output logic [AW-1:0]   aer_addr,
  output logic [TS_W-1:0] aer_ts,
  output logic            aer_eot,
  output logic [CW-1:0]   fifo_cnt,
  output logic            fifo_full,
  output logic [OVF_W-1:0] ovf_cnt
);

  typedef struct packed {
    logic            eot;
    logic [TS_W-1:0] ts;
    logic [AW-1:0]   addr;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  entry_t          head_q;
  entry_t          head_next;
  entry_t          push_entry;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   next_rd;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_after_pop;
  logic [CW-1:0]   cnt_next;
  logic [TS_W-1:0] ts;
  logic [OVF_W-1:0] ovf;
  logic            valid_q;
  logic            spike_push;
  logic            tick;
  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic            full;
  logic            marker_lost;
  logic            drop;

  assign spike_push = sys_en & update_en & sp_out;
  assign tick       = sys_en & dt_tick;

`ifdef SPIKE_OUT_EOT_EN
  logic            eot_pend;
  logic [TS_W-1:0] pend_ts;
  logic            pend_set;
  logic            pend_clr;

  // Spikes always win the single push slot; a marker waits in eot_pend until a spike-free cycle.
  always_comb begin
    push_req    = 1'b0;
    push_entry  = '0;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    marker_lost = 1'b0;
    if (spike_push) begin
      push_req   = 1'b1;
      push_entry = '{eot: 1'b0, ts: ts, addr: sp_out_wr_addr};
      if (tick) begin
        if (eot_pend) marker_lost = 1'b1;
        else          pend_set    = 1'b1;
      end
    end else if (eot_pend) begin
      push_req   = 1'b1;
      push_entry = '{eot: 1'b1, ts: pend_ts, addr: '1};
      pend_clr   = 1'b1;
      pend_set   = tick;
    end else if (tick) begin
      push_req   = 1'b1;
      push_entry = '{eot: 1'b1, ts: ts, addr: '1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      eot_pend <= 1'b0;
      pend_ts  <= '0;
    end else if (pend_set) begin
      eot_pend <= 1'b1;
      pend_ts  <= ts;
    end else if (pend_clr) begin
      eot_pend <= 1'b0;
    end
  end
`else
  always_comb begin
    push_req    = spike_push;
    push_entry  = '{eot: 1'b0, ts: ts, addr: sp_out_wr_addr};
    marker_lost = 1'b0;
  end
`endif

  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign pop     = valid_q & aer_ready;
  assign push_ok = push_req & (~full | pop);
  assign drop    = (push_req & full & ~pop) | marker_lost;

  assign cnt_after_pop = cnt - CW'(pop);
  assign cnt_next      = cnt_after_pop + CW'(push_ok);
  assign next_rd       = rd_ptr + PW'(pop);

  // Output register is preloaded with the next head; an entry pushed into an emptied FIFO bypasses memory.
  always_comb begin
    head_next = mem[next_rd];
    if (cnt_after_pop == '0) head_next = push_entry;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      ts      <= '0;
      ovf     <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      if (tick)    ts     <= ts + TS_W'(1);
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr  <= next_rd;
      cnt     <= cnt_next;
      valid_q <= (cnt_next != '0);
      if (cnt_next != '0) head_q <= head_next;
      if (drop && (ovf != '1)) ovf <= ovf + OVF_W'(1);
    end
  end

  assign aer_valid = valid_q;
  assign aer_addr  = head_q.addr;
  assign aer_ts    = head_q.ts;
  assign aer_eot   = head_q.eot;
  assign fifo_cnt  = cnt;
  assign fifo_full = full;
  assign ovf_cnt   = ovf;

endmodule
